// File: rtl/rob_commit_ctrl.sv
// Circular reorder buffer: allocates at tail, marks entries ready from the CDB,
// and retires strictly in order from head with a registered commit port.
module rob_commit_ctrl #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_dest,
  input  logic              alloc_is_store,
  output logic [IDX_W-1:0]  alloc_idx,
  output logic              full,
  output logic              empty,
  output logic [IDX_W:0]    count,
  output logic [DEPTH-1:0]  busy,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              commit_stall,
  input  logic              flush,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_idx,
  output logic [4:0]        commit_dest,
  output logic              commit_is_store,
  output logic [DATA_W-1:0] commit_data
);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  ready_q;
  logic [4:0]        dest_q  [DEPTH];
  logic              store_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [IDX_W:0]    count_q;
  logic [IDX_W:0]    count_next;

  logic do_alloc;
  logic do_wb;
  logic do_retire;

  assign alloc_idx = tail_q;
  assign busy      = busy_q;
  assign count     = count_q;
  assign full      = (count_q == (IDX_W+1)'(DEPTH));
  assign empty     = (count_q == '0);

  // full is taken from registered state, so a slot freed this cycle is not reused until next cycle
  assign do_alloc  = alloc_valid & ~full & ~flush;
  assign do_wb     = wb_valid & busy_q[wb_idx] & ~flush;
  assign do_retire = busy_q[head_q] & ready_q[head_q] & ~commit_stall & ~flush;

  always_comb begin
    count_next = count_q;
    case ({do_alloc, do_retire})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_valid    <= 1'b0;
      commit_idx      <= '0;
      commit_dest     <= '0;
      commit_is_store <= 1'b0;
      commit_data     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]  <= '0;
        store_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else if (flush) begin
      // Data fields are deliberately left untouched on flush
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= do_retire;
      count_q      <= count_next;

      if (do_alloc) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        dest_q[tail_q]  <= alloc_dest;
        store_q[tail_q] <= alloc_is_store;
        tail_q          <= tail_q + 1'b1;
      end

      if (do_wb) begin
        ready_q[wb_idx] <= 1'b1;
        data_q[wb_idx]  <= wb_data;
      end

      // Retire last so its clear wins over a redundant writeback to head
      if (do_retire) begin
        busy_q[head_q]  <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        commit_idx      <= head_q;
        commit_dest     <= dest_q[head_q];
        commit_is_store <= store_q[head_q];
        commit_data     <= data_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: inputs change 1ns after the rising edge,
// outputs are checked there against hand-computed values.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_dest;
  logic        alloc_is_store;
  logic [2:0]  alloc_idx;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic [7:0]  busy;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic [31:0] wb_data;
  logic        commit_stall;
  logic        flush;
  logic        commit_valid;
  logic [2:0]  commit_idx;
  logic [4:0]  commit_dest;
  logic        commit_is_store;
  logic [31:0] commit_data;

  int checks = 0;
  int errors = 0;

  rob_commit_ctrl #(.DEPTH(8), .IDX_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_is_store(alloc_is_store),
    .alloc_idx(alloc_idx), .full(full), .empty(empty), .count(count), .busy(busy),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .commit_stall(commit_stall), .flush(flush),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_dest(commit_dest),
    .commit_is_store(commit_is_store), .commit_data(commit_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic av, input logic [4:0] ad, input logic ast,
                                input logic wv, input logic [2:0] wi, input logic [31:0] wd);
    alloc_valid    = av;
    alloc_dest     = ad;
    alloc_is_store = ast;
    wb_valid       = wv;
    wb_idx         = wi;
    wb_data        = wd;
  endtask

  initial begin
    rst = 1'b1;
    commit_stall = 1'b0;
    flush = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);

    // Reset held for two cycles
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_busy", 64'(busy), 64'h00);
    check_output("rst_empty", 64'(empty), 64'd1);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    check_output("rst_commit_valid", 64'(commit_valid), 64'd0);

    // Nine allocations: the ninth is dropped while full
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 5'(i), 1'b0, 1'b0, 3'd0, 32'd0);
      check_output("fill_alloc_idx", 64'(alloc_idx), (i < 8) ? 64'(i) : 64'd0);
      check_output("fill_full", 64'(full), (i == 8) ? 64'd1 : 64'd0);
      tick();
    end
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("fill_count", 64'(count), 64'd8);
    check_output("fill_busy", 64'(busy), 64'hFF);
    check_output("fill_alloc_idx_after", 64'(alloc_idx), 64'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Out-of-order writebacks, in-order commit
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'(5 + i), 1'b0, 1'b0, 3'd0, 32'd0);
      tick();
    end
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd2, 32'h22);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h11);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("ooo_no_early_commit", 64'(commit_valid), 64'd0);
    tick();
    check_output("ooo_c0_valid", 64'(commit_valid), 64'd1);
    check_output("ooo_c0_idx", 64'(commit_idx), 64'd0);
    check_output("ooo_c0_data", 64'(commit_data), 64'h11);
    check_output("ooo_c0_dest", 64'(commit_dest), 64'd5);
    tick();
    check_output("ooo_wait_idx1", 64'(commit_valid), 64'd0);
    check_output("ooo_hold_data", 64'(commit_data), 64'h11);
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 32'h33);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    check_output("ooo_c1_valid", 64'(commit_valid), 64'd1);
    check_output("ooo_c1_idx", 64'(commit_idx), 64'd1);
    check_output("ooo_c1_data", 64'(commit_data), 64'h33);
    tick();
    check_output("ooo_c2_valid", 64'(commit_valid), 64'd1);
    check_output("ooo_c2_idx", 64'(commit_idx), 64'd2);
    check_output("ooo_c2_data", 64'(commit_data), 64'h22);
    check_output("ooo_c2_dest", 64'(commit_dest), 64'd7);
    tick();
    check_output("ooo_done_valid", 64'(commit_valid), 64'd0);
    check_output("ooo_empty", 64'(empty), 64'd1);

    // Head=3: allocate 3..6, make 3 ready, then allocate 7 while 3 retires
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 5'(20 + i), (i == 0), 1'b0, 3'd0, 32'd0);
      tick();
    end
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd3, 32'h44);
    tick();
    check_output("sim_count_before", 64'(count), 64'd4);
    apply_stimulus(1'b1, 5'd24, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("sim_count", 64'(count), 64'd4);
    check_output("sim_alloc_idx", 64'(alloc_idx), 64'd0);
    check_output("sim_busy", 64'(busy), 64'hF0);
    check_output("sim_commit_valid", 64'(commit_valid), 64'd1);
    check_output("sim_commit_idx", 64'(commit_idx), 64'd3);
    check_output("sim_commit_store", 64'(commit_is_store), 64'd1);
    check_output("sim_commit_data", 64'(commit_data), 64'h44);

    // Stall with head (entry 4) ready
    commit_stall = 1'b1;
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd4, 32'h55);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stall_no_commit", 64'(commit_valid), 64'd0);
      check_output("stall_busy", 64'(busy), 64'hF0);
    end
    commit_stall = 1'b0;
    tick();
    check_output("stall_release_valid", 64'(commit_valid), 64'd1);
    check_output("stall_release_idx", 64'(commit_idx), 64'd4);
    check_output("stall_release_data", 64'(commit_data), 64'h55);
    check_output("stall_release_dest", 64'(commit_dest), 64'd21);
    check_output("stall_release_store", 64'(commit_is_store), 64'd0);

    // Mid-operation reset restores the power-up state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_busy", 64'(busy), 64'h00);
    check_output("midrst_count", 64'(count), 64'd0);
    check_output("midrst_commit_idx", 64'(commit_idx), 64'd0);
    check_output("midrst_commit_data", 64'(commit_data), 64'd0);

    // Twelve alloc/retire pairs: indices wrap 7 -> 0
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, 5'(i), 1'b0, 1'b0, 3'd0, 32'd0);
      check_output("wrap_alloc_idx", 64'(alloc_idx), 64'(i % 8));
      tick();
      apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'(i % 8), 32'(100 + i));
      tick();
      apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
      tick();
      check_output("wrap_commit_valid", 64'(commit_valid), 64'd1);
      check_output("wrap_commit_idx", 64'(commit_idx), 64'(i % 8));
      check_output("wrap_commit_data", 64'(commit_data), 64'(100 + i));
    end
    check_output("wrap_empty", 64'(empty), 64'd1);

    // Five entries (4,5,6,7,0) then flush with a same-cycle writeback to head
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 5'(i), 1'b0, 1'b0, 3'd0, 32'd0);
      tick();
    end
    check_output("flush_pre_busy", 64'(busy), 64'hF1);
    apply_stimulus(1'b1, 5'd9, 1'b0, 1'b1, 3'd4, 32'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("flush_busy", 64'(busy), 64'h00);
    check_output("flush_empty", 64'(empty), 64'd1);
    check_output("flush_count", 64'(count), 64'd0);
    check_output("flush_alloc_idx", 64'(alloc_idx), 64'd0);
    check_output("flush_commit_valid", 64'(commit_valid), 64'd0);
    tick();
    check_output("flush_no_late_commit", 64'(commit_valid), 64'd0);
    apply_stimulus(1'b1, 5'd3, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("flush_next_alloc_idx", 64'(alloc_idx), 64'd0);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check_output("flush_next_busy", 64'(busy), 64'h01);
    check_output("flush_next_commit", 64'(commit_valid), 64'd0);

    // Writeback to a non-busy entry is ignored
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b1, 3'd5, 32'h77);
    tick();
    apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    tick();
    check_output("wb_nonbusy_no_commit", 64'(commit_valid), 64'd0);
    check_output("wb_nonbusy_count", 64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
